// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared types and default constants for the PLL lock sequencer
//
// Contents:
//   pll_state_t       sequencer FSM states
//   DEF_*             default values for the pll_lock_seq parameters
//   RETRY_W           width of the retry counter output
//   max3()            largest of three cycle counts, used to size the shared counter

package pll_seq_pkg;

    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_state_t;

    localparam int DEF_RST_HOLD_CYC     = 100;     // 2 us at 50 MHz
    localparam int DEF_LOCK_TIMEOUT_CYC = 50000;   // 1 ms at 50 MHz
    localparam int DEF_LOCK_STABLE_CYC  = 1024;
    localparam int DEF_MAX_RETRY        = 7;
    localparam int DEF_SYNC_STAGES      = 2;

    localparam int RETRY_W = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-flop synchroniser for asynchronous level signals
//
// Ports:
//   clk    in            destination clock
//   rst_n  in            async active-low reset, clears every stage
//   d      in  [WIDTH]   asynchronous input
//   q      out [WIDTH]   input delayed by STAGES destination-clock edges
//
// Each bit is synchronised independently; only use WIDTH>1 for bits that
// do not need to be sampled coherently. STAGES must be at least 2.

module sync_ff #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[STAGES-2:0], d};
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/pll_lock_seq.sv
// rtl/pll_lock_seq.sv - PLL reset/lock sequencer generating the PLL-domain system reset
//
// Ports:
//   refclk         in       free-running 50 MHz board clock
//   reset_n        in       async active-low board reset
//   pll_extlock    in       PLL lock indication, asynchronous to refclk
//   pll_reset      out      PLL reset pin, active-high
//   sys_rst_n      out      active-low reset for PLL-clocked logic, high only in RUN
//   pll_ready      out      high only in RUN
//   pll_fail       out      sticky, retries exhausted
//   lock_loss_cnt  out [8]  saturating count of RUN lock-loss events (PLL_LOSS_CNT_EN only)
//   retry_cnt      out [4]  retries used in the current power-up sequence
//
// Build option: define PLL_LOSS_CNT_EN to add the lock_loss_cnt port and counter.
//
// All outputs are registered and decoded from the next state, so each output
// changes on the same edge as the state it belongs to.

module pll_lock_seq
    import pll_seq_pkg::*;
#(
    parameter int RST_HOLD_CYC     = DEF_RST_HOLD_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int MAX_RETRY        = DEF_MAX_RETRY,
    parameter int SYNC_STAGES      = DEF_SYNC_STAGES
) (
    input  logic               refclk,
    input  logic               reset_n,
    input  logic               pll_extlock,
    output logic               pll_reset,
    output logic               sys_rst_n,
    output logic               pll_ready,
    output logic               pll_fail,
`ifdef PLL_LOSS_CNT_EN
    output logic [7:0]         lock_loss_cnt,
`endif
    output logic [RETRY_W-1:0] retry_cnt
);

    // One counter serves every timed state, so it only needs to reach the
    // largest terminal value minus one.
    localparam int CNT_MAX = max3(RST_HOLD_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC);
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    // The WAIT_LOCK cycle that saw lock_s high is the first of the qualifying
    // run, so STABLE itself needs one cycle fewer than LOCK_STABLE_CYC.
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 2);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    logic               lock_s;
    pll_state_t         state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [RETRY_W-1:0] retry_nxt;
    logic               pll_reset_nxt;
    logic               run_nxt;
    logic               fail_nxt;

    sync_ff #(
        .WIDTH  (1),
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (refclk),
        .rst_n (reset_n),
        .d     (pll_extlock),
        .q     (lock_s)
    );

    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= HOLD;
            cnt       <= '0;
            retry_cnt <= '0;
            pll_reset <= 1'b1;
            sys_rst_n <= 1'b0;
            pll_ready <= 1'b0;
            pll_fail  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            retry_cnt <= retry_nxt;
            pll_reset <= pll_reset_nxt;
            sys_rst_n <= run_nxt;
            pll_ready <= run_nxt;
            pll_fail  <= fail_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        retry_nxt = retry_cnt;

        case (state)
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_nxt = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                // Lock takes priority over a timeout landing on the same cycle.
                if (lock_s) begin
                    state_nxt = STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    if (retry_cnt == RETRY_LIMIT) begin
                        state_nxt = FAIL;
                    end else begin
                        retry_nxt = retry_cnt + 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            STABLE: begin
                // A drop goes back to WAIT_LOCK with a fresh timeout but keeps
                // the retry budget: the PLL did lock, it is just settling.
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // Lock loss after a good run starts a new power-up sequence.
                if (!lock_s) begin
                    state_nxt = HOLD;
                    retry_nxt = '0;
                end
            end
            FAIL: begin
                state_nxt = FAIL;
            end
            default: begin
                state_nxt = HOLD;
            end
        endcase

        // RUN and FAIL are untimed; parking the counter at zero keeps it
        // from wrapping while they last.
        if ((state_nxt != state) || (state == RUN) || (state == FAIL)) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end

        pll_reset_nxt = (state_nxt == HOLD) || (state_nxt == FAIL);
        run_nxt       = (state_nxt == RUN);
        fail_nxt      = (state_nxt == FAIL);
    end

`ifdef PLL_LOSS_CNT_EN
    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            lock_loss_cnt <= '0;
        end else if ((state == RUN) && !lock_s && (lock_loss_cnt != 8'hFF)) begin
            lock_loss_cnt <= lock_loss_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pll_lock_seq.sv
// tb/tb_pll_lock_seq.sv - scoreboard bench for pll_lock_seq
//
// Observed vector per sample: {pll_reset, sys_rst_n, pll_ready, pll_fail, retry_cnt[3:0]}.
// Cycle c means "sampled on the falling edge after rising edge c", where edge 0
// is the edge after which reset_n was released. Stimulus written in iteration c
// is first seen by the synchroniser at edge c+1, so lock_s follows at edge c+2.

module tb_pll_lock_seq;

    logic       refclk;
    logic       reset_n;
    logic       pll_extlock;
    logic       pll_reset;
    logic       sys_rst_n;
    logic       pll_ready;
    logic       pll_fail;
    logic [3:0] retry_cnt;
`ifdef PLL_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt;
`endif

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    pll_lock_seq #(
        .RST_HOLD_CYC     (4),
        .LOCK_TIMEOUT_CYC (20),
        .LOCK_STABLE_CYC  (8),
        .MAX_RETRY        (2),
        .SYNC_STAGES      (2)
    ) dut (
        .refclk        (refclk),
        .reset_n       (reset_n),
        .pll_extlock   (pll_extlock),
        .pll_reset     (pll_reset),
        .sys_rst_n     (sys_rst_n),
        .pll_ready     (pll_ready),
        .pll_fail      (pll_fail),
`ifdef PLL_LOSS_CNT_EN
        .lock_loss_cnt (lock_loss_cnt),
`endif
        .retry_cnt     (retry_cnt)
    );

    initial refclk = 1'b0;
    always #10 refclk = ~refclk;

    function automatic logic [7:0] obs();
        return {pll_reset, sys_rst_n, pll_ready, pll_fail, retry_cnt};
    endfunction

    task automatic expect_at(input int c, input logic [7:0] v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic apply_reset();
        reset_n     = 1'b0;
        pll_extlock = 1'b0;
        repeat (3) @(posedge refclk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        reset_n     = 1'b0;
        pll_extlock = 1'b1;
        expect_at(1, 8'b1000_0000);
        expect_at(3, 8'b1000_0000);
        expect_at(6, 8'b1000_0000);
        for (int c = 1; c <= 6; c++) begin
            @(posedge refclk); #1;
            @(negedge refclk);
            if (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                n_checks++;
                if (obs() !== e.val) begin
                    n_fail++;
                    $display("FAIL reset c=%0d got=%b exp=%b", c, obs(), e.val);
                end
            end
        end
`ifdef PLL_LOSS_CNT_EN
        n_checks++;
        if (lock_loss_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_loss_cnt got=%0d exp=0", lock_loss_cnt);
        end
`endif
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++; n_fail++;
            $display("FAIL reset unconsumed c=%0d", e.cyc);
        end
    endtask

    task automatic test_basic_lock();
        exp_t e;
        apply_reset();
        expect_at(1,  8'b1000_0000);
        expect_at(3,  8'b1000_0000);
        expect_at(4,  8'b0000_0000);
        expect_at(12, 8'b0000_0000);
        expect_at(19, 8'b0000_0000);
        expect_at(20, 8'b0110_0000);
        expect_at(30, 8'b0110_0000);
        for (int c = 1; c <= 32; c++) begin
            @(posedge refclk); #1;
            if (c == 10) pll_extlock = 1'b1;
            @(negedge refclk);
            if (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                n_checks++;
                if (obs() !== e.val) begin
                    n_fail++;
                    $display("FAIL basic_lock c=%0d got=%b exp=%b", c, obs(), e.val);
                end
            end
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++; n_fail++;
            $display("FAIL basic_lock unconsumed c=%0d", e.cyc);
        end
    endtask

    task automatic test_retry_fail();
        exp_t e;
        apply_reset();
        expect_at(23,  8'b0000_0000);
        expect_at(24,  8'b1000_0001);
        expect_at(27,  8'b1000_0001);
        expect_at(28,  8'b0000_0001);
        expect_at(47,  8'b0000_0001);
        expect_at(48,  8'b1000_0010);
        expect_at(52,  8'b0000_0010);
        expect_at(71,  8'b0000_0010);
        expect_at(72,  8'b1001_0010);
        expect_at(100, 8'b1001_0010);
        for (int c = 1; c <= 100; c++) begin
            @(posedge refclk); #1;
            @(negedge refclk);
            if (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                n_checks++;
                if (obs() !== e.val) begin
                    n_fail++;
                    $display("FAIL retry_fail c=%0d got=%b exp=%b", c, obs(), e.val);
                end
            end
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++; n_fail++;
            $display("FAIL retry_fail unconsumed c=%0d", e.cyc);
        end
    endtask

    task automatic test_stable_glitch();
        exp_t e;
        apply_reset();
        expect_at(7,  8'b0000_0000);
        expect_at(14, 8'b0000_0000);
        expect_at(15, 8'b0000_0000);
        expect_at(22, 8'b0000_0000);
        expect_at(23, 8'b0110_0000);
        expect_at(26, 8'b0110_0000);
        for (int c = 1; c <= 27; c++) begin
            @(posedge refclk); #1;
            if (c == 5)  pll_extlock = 1'b1;
            if (c == 12) pll_extlock = 1'b0;
            if (c == 13) pll_extlock = 1'b1;
            @(negedge refclk);
            if (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                n_checks++;
                if (obs() !== e.val) begin
                    n_fail++;
                    $display("FAIL stable_glitch c=%0d got=%b exp=%b", c, obs(), e.val);
                end
            end
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++; n_fail++;
            $display("FAIL stable_glitch unconsumed c=%0d", e.cyc);
        end
    endtask

    task automatic test_run_loss();
        exp_t e;
        logic got;
        apply_reset();
        expect_at(24, 8'b1000_0001);
        expect_at(28, 8'b0000_0001);
        expect_at(35, 8'b0000_0001);
        expect_at(36, 8'b0110_0001);
        expect_at(42, 8'b0110_0001);
        expect_at(43, 8'b1000_0000);
        expect_at(46, 8'b1000_0000);
        expect_at(47, 8'b0000_0000);
        expect_at(54, 8'b0000_0000);
        expect_at(55, 8'b0110_0000);
        for (int c = 1; c <= 58; c++) begin
            @(posedge refclk); #1;
            if (c == 26) pll_extlock = 1'b1;
            if (c == 40) pll_extlock = 1'b0;
            if (c == 43) pll_extlock = 1'b1;
            @(negedge refclk);
            if (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                n_checks++;
                if (obs() !== e.val) begin
                    n_fail++;
                    $display("FAIL run_loss c=%0d got=%b exp=%b", c, obs(), e.val);
                end
            end
`ifdef PLL_LOSS_CNT_EN
            if (c == 43) begin
                n_checks++;
                if (lock_loss_cnt !== 8'd1) begin
                    n_fail++;
                    $display("FAIL run_loss_cnt1 got=%0d exp=1", lock_loss_cnt);
                end
            end
`endif
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++; n_fail++;
            $display("FAIL run_loss unconsumed c=%0d", e.cyc);
        end
`ifdef PLL_LOSS_CNT_EN
        // 260 more losses on top of the first one: the counter must saturate.
        for (int r = 0; r < 260; r++) begin
            @(posedge refclk); #1;
            pll_extlock = 1'b0;
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                @(negedge refclk);
                got = !pll_ready;
            end
            @(posedge refclk); #1;
            pll_extlock = 1'b1;
            if (got) begin
                got = 1'b0;
                for (int k = 0; k < 40 && !got; k++) begin
                    @(negedge refclk);
                    got = pll_ready;
                end
            end
            if (!got) begin
                n_checks++; n_fail++;
                $display("FAIL run_loss_repeat r=%0d got=ready_timeout exp=relock", r);
                break;
            end
        end
        @(negedge refclk);
        n_checks++;
        if (lock_loss_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL run_loss_sat got=%0d exp=255", lock_loss_cnt);
        end
`endif
    endtask

    task automatic test_lock_at_timeout();
        exp_t e;
        apply_reset();
        expect_at(23, 8'b0000_0000);
        expect_at(24, 8'b0000_0000);
        expect_at(30, 8'b0000_0000);
        expect_at(31, 8'b0110_0000);
        for (int c = 1; c <= 33; c++) begin
            @(posedge refclk); #1;
            if (c == 21) pll_extlock = 1'b1;
            @(negedge refclk);
            if (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                n_checks++;
                if (obs() !== e.val) begin
                    n_fail++;
                    $display("FAIL lock_at_timeout c=%0d got=%b exp=%b", c, obs(), e.val);
                end
            end
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++; n_fail++;
            $display("FAIL lock_at_timeout unconsumed c=%0d", e.cyc);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        // Part 1: reset hits while qualifying lock in STABLE.
        apply_reset();
        expect_at(9, 8'b0000_0000);
        for (int c = 1; c <= 10; c++) begin
            @(posedge refclk); #1;
            if (c == 5) pll_extlock = 1'b1;
            @(negedge refclk);
            if (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                n_checks++;
                if (obs() !== e.val) begin
                    n_fail++;
                    $display("FAIL async_stable_pre c=%0d got=%b exp=%b", c, obs(), e.val);
                end
            end
        end
        @(posedge refclk); #3;
        reset_n = 1'b0;
        expect_at(0, 8'b1000_0000);
        #1;
        e = sb.pop_front();
        n_checks++;
        if (obs() !== e.val) begin
            n_fail++;
            $display("FAIL async_stable_now got=%b exp=%b", obs(), e.val);
        end
        repeat (2) @(posedge refclk);
        #1;
        reset_n = 1'b1;
        expect_at(3,  8'b1000_0000);
        expect_at(4,  8'b0000_0000);
        expect_at(11, 8'b0000_0000);
        expect_at(12, 8'b0110_0000);
        for (int c = 1; c <= 14; c++) begin
            @(posedge refclk); #1;
            @(negedge refclk);
            if (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                n_checks++;
                if (obs() !== e.val) begin
                    n_fail++;
                    $display("FAIL async_stable_restart c=%0d got=%b exp=%b", c, obs(), e.val);
                end
            end
        end
        // Part 2: reset out of the terminal FAIL state.
        apply_reset();
        expect_at(72, 8'b1001_0010);
        expect_at(75, 8'b1001_0010);
        for (int c = 1; c <= 75; c++) begin
            @(posedge refclk); #1;
            @(negedge refclk);
            if (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                n_checks++;
                if (obs() !== e.val) begin
                    n_fail++;
                    $display("FAIL async_fail_pre c=%0d got=%b exp=%b", c, obs(), e.val);
                end
            end
        end
        #3;
        reset_n = 1'b0;
        expect_at(0, 8'b1000_0000);
        #1;
        e = sb.pop_front();
        n_checks++;
        if (obs() !== e.val) begin
            n_fail++;
            $display("FAIL async_fail_now got=%b exp=%b", obs(), e.val);
        end
        repeat (2) @(posedge refclk);
        #1;
        reset_n = 1'b1;
        expect_at(4,  8'b0000_0000);
        expect_at(23, 8'b0000_0000);
        expect_at(24, 8'b1000_0001);
        for (int c = 1; c <= 25; c++) begin
            @(posedge refclk); #1;
            @(negedge refclk);
            if (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                n_checks++;
                if (obs() !== e.val) begin
                    n_fail++;
                    $display("FAIL async_fail_restart c=%0d got=%b exp=%b", c, obs(), e.val);
                end
            end
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++; n_fail++;
            $display("FAIL async_reset unconsumed c=%0d", e.cyc);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=time_limit exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n     = 1'b0;
        pll_extlock = 1'b0;
        test_reset();
        test_basic_lock();
        test_retry_fail();
        test_stable_glitch();
        test_run_loss();
        test_lock_at_timeout();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
